// File: rtl/div_unit.sv
// Iterative 32-bit integer divider: DIV/DIVU/REM/REMU with one quotient bit per cycle.
// Divide-by-zero and signed overflow skip the iteration and complete in one cycle.
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic [4:0]  rd,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        w_en,
  output logic [4:0]  w_addr
);

  // state | meaning
  // IDLE  | waiting for start; operands latched on accept
  // CALC  | 32 restoring shift-subtract iterations
  // DONE  | one-cycle result/write pulse
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state_q;
  logic [4:0]  cnt_q;
  logic [31:0] quo_q;
  logic [31:0] rem_q;
  logic [31:0] dvs_q;
  logic        sel_rem_q;
  logic        neg_q;
  logic [4:0]  rd_q;

  logic        sgn;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic        neg_in;
  logic        div0;
  logic        ovf;
  logic [31:0] special_res;
  logic [32:0] rem_sh;
  logic [32:0] diff;
  logic [31:0] rem_nx;
  logic [31:0] quo_nx;
  logic [31:0] mag_res;
  logic [31:0] final_res;

  always_comb begin
    sgn         = ~op[0];
    a_mag       = (sgn && rs1[31]) ? -rs1 : rs1;
    b_mag       = (sgn && rs2[31]) ? -rs2 : rs2;
    // remainder follows the dividend sign, quotient follows the sign XOR
    neg_in      = op[1] ? (sgn & rs1[31]) : (sgn & (rs1[31] ^ rs2[31]));
    div0        = (rs2 == 32'd0);
    ovf         = sgn && (rs1 == 32'h8000_0000) && (rs2 == 32'hFFFF_FFFF);
    if (div0) special_res = op[1] ? rs1 : 32'hFFFF_FFFF;
    else      special_res = op[1] ? 32'd0 : 32'h8000_0000;

    rem_sh      = {rem_q, quo_q[31]};
    diff        = rem_sh - {1'b0, dvs_q};
    rem_nx      = diff[32] ? rem_sh[31:0] : diff[31:0];
    quo_nx      = {quo_q[30:0], ~diff[32]};
    mag_res     = sel_rem_q ? rem_nx : quo_nx;
    final_res   = neg_q ? -mag_res : mag_res;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 5'd0;
      quo_q     <= 32'd0;
      rem_q     <= 32'd0;
      dvs_q     <= 32'd0;
      sel_rem_q <= 1'b0;
      neg_q     <= 1'b0;
      rd_q      <= 5'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      w_en      <= 1'b0;
      result    <= 32'd0;
      w_addr    <= 5'd0;
    end else begin
      case (state_q)
        IDLE: begin
          done <= 1'b0;
          w_en <= 1'b0;
          if (start) begin
            busy <= 1'b1;
            rd_q <= rd;
            if (div0 || ovf) begin
              state_q <= DONE;
              done    <= 1'b1;
              w_en    <= (rd != 5'd0);
              w_addr  <= rd;
              result  <= special_res;
            end else begin
              state_q   <= CALC;
              quo_q     <= a_mag;
              rem_q     <= 32'd0;
              dvs_q     <= b_mag;
              sel_rem_q <= op[1];
              neg_q     <= neg_in;
              cnt_q     <= 5'd31;
            end
          end
        end
        CALC: begin
          quo_q <= quo_nx;
          rem_q <= rem_nx;
          if (cnt_q == 5'd0) begin
            state_q <= DONE;
            done    <= 1'b1;
            w_en    <= (rd_q != 5'd0);
            w_addr  <= rd_q;
            result  <= final_res;
          end else begin
            cnt_q <= cnt_q - 5'd1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
          w_en    <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
          w_en    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: directed vectors push expected results, a monitor checks each done pulse.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [4:0]  rd;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        w_en;
  logic [4:0]  w_addr;

  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

  typedef struct {
    logic [31:0] res;
    logic        we;
    logic [4:0]  addr;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;

  div_unit dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .rs1(rs1), .rs2(rs2), .rd(rd),
    .busy(busy), .done(done), .result(result), .w_en(w_en), .w_addr(w_addr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: every done/w_en cycle must match the oldest expected entry
  always @(negedge clk) begin
    if (!rst && (done || w_en)) begin
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_done: done=%0b w_en=%0b result=0x%08h with no pending op (cycle %0d)",
                 done, w_en, result, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_cycle", 32'(cyc), 32'(e.cyc));
        chk("done", {31'd0, done}, 32'd1);
        chk("result", result, e.res);
        chk("w_en", {31'd0, w_en}, {31'd0, e.we});
        chk("w_addr", {27'd0, w_addr}, {27'd0, e.addr});
      end
    end
  end

  // called #1 after a rising edge; start is sampled at the next edge
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] r, input logic [31:0] exp_res, input int lat,
                       output int s);
    exp_t e;
    s      = cyc;
    e.res  = exp_res;
    e.we   = (r != 5'd0);
    e.addr = r;
    e.cyc  = s + lat;
    sb.push_back(e);
    op = o; rs1 = a; rs2 = b; rd = r; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    op  = 2'($urandom_range(0, 3));
    rs1 = $urandom;
    rs2 = $urandom;
    rd  = 5'($urandom_range(0, 31));
    chk("busy_cycle1", {31'd0, busy}, 32'd1);
  endtask

  task automatic run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] r, input logic [31:0] exp_res, input int lat);
    int s;
    issue(o, a, b, r, exp_res, lat, s);
    while (cyc < s + lat + 1) begin
      @(posedge clk); #1;
    end
    chk("busy_after_done", {31'd0, busy}, 32'd0);
    chk("result_pending", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  initial begin
    int s;
    // reset asserted together with a start request: reset wins
    rst = 1'b1; start = 1'b1; op = OP_DIVU; rs1 = 32'd9; rs2 = 32'd3; rd = 5'd7;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; start = 1'b0;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_w_en", {31'd0, w_en}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_w_addr", {27'd0, w_addr}, 32'd0);
    @(posedge clk); #1;

    run(OP_DIVU, 32'd100,         32'd7,           5'd5,  32'd14,          33);
    run(OP_DIV,  32'hFFFF_FFF9,   32'd2,           5'd1,  32'hFFFF_FFFD,   33);
    run(OP_REM,  32'hFFFF_FFF9,   32'd2,           5'd2,  32'hFFFF_FFFF,   33);
    run(OP_REMU, 32'hFFFF_FFF9,   32'd2,           5'd3,  32'd1,           33);
    run(OP_DIV,  32'hFFFF_FF9C,   32'd7,           5'd6,  32'hFFFF_FFF2,   33);
    run(OP_REM,  32'd100,         32'hFFFF_FFF9,   5'd8,  32'd2,           33);
    run(OP_DIVU, 32'hFFFF_FFFF,   32'd1,           5'd10, 32'hFFFF_FFFF,   33);
    run(OP_REMU, 32'hFFFF_FFFF,   32'hFFFF_FFFE,   5'd11, 32'd1,           33);
    run(OP_DIVU, 32'h8000_0000,   32'hFFFF_FFFF,   5'd12, 32'd0,           33);
    run(OP_DIV,  32'd5,           32'd0,           5'd4,  32'hFFFF_FFFF,   1);
    run(OP_REMU, 32'd5,           32'd0,           5'd4,  32'd5,           1);
    run(OP_REM,  32'hFFFF_FFF9,   32'd0,           5'd13, 32'hFFFF_FFF9,   1);
    run(OP_DIV,  32'h8000_0000,   32'hFFFF_FFFF,   5'd14, 32'h8000_0000,   1);
    run(OP_REM,  32'h8000_0000,   32'hFFFF_FFFF,   5'd15, 32'd0,           1);
    run(OP_DIVU, 32'd20,          32'd3,           5'd0,  32'd6,           33);

    // abort by reset in cycle 10: nothing may complete, next op runs normally
    s = cyc;
    op = OP_DIVU; rs1 = 32'd1000; rs2 = 32'd10; rd = 5'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (cyc < s + 10) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    @(posedge clk); #1;
    chk("abort_restart_cycle", 32'(cyc - s), 32'd12);
    run(OP_DIVU, 32'd1000, 32'd10, 5'd9, 32'd100, 33);

    // starts with new operands in cycles 5 and 33 (DONE) are ignored
    issue(OP_DIVU, 32'd77, 32'd7, 5'd9, 32'd11, 33, s);
    while (cyc < s + 5) begin
      @(posedge clk); #1;
    end
    op = OP_DIV; rs1 = 32'd1; rs2 = 32'd1; rd = 5'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (cyc < s + 33) begin
      @(posedge clk); #1;
    end
    op = OP_DIV; rs1 = 32'd2; rs2 = 32'd1; rd = 5'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("ignore_busy_after_done", {31'd0, busy}, 32'd0);
    repeat (40) begin
      @(posedge clk); #1;
    end
    chk("ignore_result_held", result, 32'd11);
    chk("ignore_pending", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 Parameters: none; operand width is fixed at 32 bits and register address width at 5 bits.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to begin a divide; sampled only in IDLE.
REQ-005 op  input  2  00 DIV (signed quotient), 01 DIVU, 10 REM (signed remainder), 11 REMU.
REQ-006 rs1  input  32  dividend, taken from register-file read port 1.
REQ-007 rs2  input  32  divisor, taken from register-file read port 2.
REQ-008 rd  input  5  destination register address for the result.
REQ-009 busy  output  1  high while an operation is in progress; start is ignored while busy is high.
REQ-010 done  output  1  one-cycle pulse; result is valid in that cycle.
REQ-011 result  output  32  quotient or remainder; held stable from done until the next accepted start.
REQ-012 w_en  output  1  register-file write enable; equals done AND (latched rd != 0).
REQ-013 w_addr  output  5  latched rd; drives the register-file write address.

Function
REQ-014 FSM states: IDLE, CALC, DONE; the block SHALL leave reset in IDLE.
REQ-015 IDLE with start=1 SHALL latch op, rs1, rs2 and rd on that edge; later changes to the inputs SHALL NOT affect the operation.
REQ-016 Accepted start with rs2==0 SHALL go IDLE->DONE; DIV/DIVU result = 0xFFFFFFFF, REM/REMU result = rs1.
REQ-017 Accepted start with op=DIV or REM, rs1=0x80000000 and rs2=0xFFFFFFFF SHALL go IDLE->DONE; DIV result = 0x80000000, REM result = 0.
REQ-018 Any other accepted start SHALL go IDLE->CALC and run a restoring shift-subtract on unsigned magnitudes, one quotient bit per cycle, for exactly 32 cycles, then go CALC->DONE.
REQ-019 Signed ops SHALL divide the magnitudes of both operands.
REQ-020 The signed quotient SHALL be negated when the operand signs differ.
REQ-021 The signed remainder SHALL take the sign of the dividend.
REQ-022 DONE SHALL last exactly one cycle and then return to IDLE.
REQ-023 done=1 and w_en per REQ-012 SHALL hold only in DONE.
REQ-024 result and w_addr SHALL update on the edge that enters DONE.
REQ-025 Latency: start sampled in cycle 0 -> busy=1 in cycles 1..33 -> done in cycle 33 (normal path) or cycle 1 (REQ-016/017 paths); busy=0 in the cycle after done.
REQ-026 A start in any state other than IDLE, including DONE, SHALL be ignored with no effect on state or latched values.
REQ-027 Intermediate arithmetic SHALL use a 33-bit partial remainder so the subtract never overflows; there SHALL be no wrap-around error for any operand pair.

Reset
REQ-028 rst=1 at an edge SHALL force IDLE.
REQ-029 rst=1 at an edge SHALL force busy=0, done=0, w_en=0, result=0, w_addr=0.
REQ-030 rst=1 at an edge SHALL clear the iteration counter and all latched operands.
REQ-031 rst SHALL take priority over start in the same cycle.
REQ-032 An operation aborted by rst SHALL never produce done or w_en.

Verification
REQ-033 DIVU rs1=100, rs2=7, rd=5, start in cycle 0 -> cycle 33: done=1, result=14, w_en=1, w_addr=5; cycle 34: busy=0.
REQ-034 DIV 0xFFFFFFF9 / 2 -> result 0xFFFFFFFD (-3); REM with the same operands -> result 0xFFFFFFFF (-1); REMU 0xFFFFFFF9 % 2 -> result 1.
REQ-035 DIV 5/0 -> done in cycle 1, result 0xFFFFFFFF; REMU 5%0 -> done in cycle 1, result 5.
REQ-036 DIV 0x80000000 / 0xFFFFFFFF -> done in cycle 1, result 0x80000000; REM with the same operands -> result 0.
REQ-037 Start DIVU, assert rst in cycle 10 -> cycle 11: busy=0, done=0; no done or w_en ever follows; a new start in cycle 12 completes normally in cycle 45.
REQ-038 A start pulse with new operands in cycles 5 and 33 of an active operation is ignored, and the original result is delivered; an op with rd=0 gives done=1 with w_en=0.
